vram_scanout: RTL

- Read side of the VRAM frame-buffer path. The CPU snoop block writes the Mac SE framebuffer into VRAM. This block generates 640x480@60Hz VGA timing, fetches VRAM bytes in the non-write sequence slots, and shifts out 1-bit pixels.
- The 512x342 Mac image is centred in the 640x480 raster with a black border.
- The block owns the horizontal/vertical counters and exports seq (hCount[2:0]) to the snoop block.

---
 rtl/vram_scanout.sv | 133 +++++++++++++
 1 files changed

// File: rtl/vram_scanout.sv
// VGA 640x480@60 scanout of the Mac SE framebuffer held in VRAM: raster timing,
// VRAM reads in the non-write sequence slots, and a 1-bit pixel shifter.
module vram_scanout #(
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33,
  parameter int MAC_X0 = 64,
  parameter int MAC_Y0 = 69,
  parameter int MAC_W  = 512,
  parameter int MAC_H  = 342
) (
  input  logic        pixClock,
  input  logic        nReset,
  output logic [2:0]  seq,
  output logic [14:0] vramAddr,
  output logic        nvramOE,
  input  logic [7:0]  vramDataIn,
  output logic        hSync,
  output logic        vSync,
  output logic        vidOut,
  output logic        vidActive
);

  localparam logic [9:0] H_LAST     = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST     = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_VIS_C    = 10'(H_VIS);
  localparam logic [9:0] V_VIS_C    = 10'(V_VIS);
  localparam logic [9:0] HS_START   = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END     = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] VS_START   = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END     = 10'(V_VIS + V_FP + V_SYNC);
  localparam logic [9:0] MAC_X_LO   = 10'(MAC_X0);
  localparam logic [9:0] MAC_X_HI   = 10'(MAC_X0 + MAC_W);
  localparam logic [9:0] MAC_Y_LO   = 10'(MAC_Y0);
  localparam logic [9:0] MAC_Y_HI   = 10'(MAC_Y0 + MAC_H);
  localparam logic [9:0] FETCH_X_LO = 10'(MAC_X0 - 8);
  localparam logic [9:0] FETCH_X_HI = 10'(MAC_X0 + MAC_W - 8);

  logic [9:0]  r_hCount;
  logic [9:0]  r_vCount;
  logic [13:0] r_wordCnt;
  logic        r_byteSel;
  logic [7:0]  r_fetchBuf;
  logic [7:0]  r_shiftReg;
  logic        r_hSync;
  logic        r_vSync;
  logic        r_vidOut;
  logic        r_vidActive;

  logic w_hLast;
  logic w_vLast;
  logic w_macLines;
  logic w_macWin;
  logic w_fetch;
  logic w_oe;

  assign w_hLast    = (r_hCount == H_LAST);
  assign w_vLast    = (r_vCount == V_LAST);
  assign w_macLines = (r_vCount >= MAC_Y_LO) && (r_vCount < MAC_Y_HI);
  assign w_macWin   = w_macLines && (r_hCount >= MAC_X_LO) && (r_hCount < MAC_X_HI);
  // Fetches run one column ahead of the displayed pixels.
  assign w_fetch    = w_macLines && (r_hCount >= FETCH_X_LO) && (r_hCount < FETCH_X_HI);
  assign w_oe       = w_fetch && (seq >= 3'd4) && (seq <= 3'd6);

  assign seq       = r_hCount[2:0];
  assign nvramOE   = ~w_oe;
  assign vramAddr  = w_oe ? {r_wordCnt, ~r_byteSel} : 15'd0;
  assign hSync     = r_hSync;
  assign vSync     = r_vSync;
  assign vidOut    = r_vidOut;
  assign vidActive = r_vidActive;

  always_ff @(posedge pixClock or negedge nReset) begin
    if (!nReset) begin
      r_hCount <= 10'd0;
      r_vCount <= 10'd0;
    end else if (w_hLast) begin
      r_hCount <= 10'd0;
      r_vCount <= w_vLast ? 10'd0 : r_vCount + 10'd1;
    end else begin
      r_hCount <= r_hCount + 10'd1;
    end
  end

  // Snoop stores each big-endian word's high byte at the odd address, so odd goes first.
  always_ff @(posedge pixClock or negedge nReset) begin
    if (!nReset) begin
      r_wordCnt  <= 14'd0;
      r_byteSel  <= 1'b0;
      r_fetchBuf <= 8'd0;
    end else if (w_hLast && w_vLast) begin
      r_wordCnt <= 14'd0;
      r_byteSel <= 1'b0;
    end else if (w_fetch && (seq == 3'd6)) begin
      r_fetchBuf <= vramDataIn;
      r_byteSel  <= ~r_byteSel;
      if (r_byteSel) begin
        r_wordCnt <= r_wordCnt + 14'd1;
      end
    end
  end

  always_ff @(posedge pixClock or negedge nReset) begin
    if (!nReset) begin
      r_shiftReg <= 8'd0;
    end else if (w_fetch && (seq == 3'd7)) begin
      r_shiftReg <= r_fetchBuf;
    end else begin
      r_shiftReg <= {r_shiftReg[6:0], 1'b0};
    end
  end

  // Mac pixels are 1 = black; everything outside the Mac window is border black.
  always_ff @(posedge pixClock or negedge nReset) begin
    if (!nReset) begin
      r_hSync     <= 1'b1;
      r_vSync     <= 1'b1;
      r_vidOut    <= 1'b0;
      r_vidActive <= 1'b0;
    end else begin
      r_hSync     <= !((r_hCount >= HS_START) && (r_hCount < HS_END));
      r_vSync     <= !((r_vCount >= VS_START) && (r_vCount < VS_END));
      r_vidActive <= (r_hCount < H_VIS_C) && (r_vCount < V_VIS_C);
      r_vidOut    <= w_macWin && !r_shiftReg[7];
    end
  end

endmodule
